// File: rtl/gpu_data_mem_responder.sv
// Data-memory responder for the miniGPU core: fixed-latency read/write service of the
// core port plus a host preload port, one outstanding request at a time.
module gpu_data_mem_responder #(
   parameter int ADDR_BITS     = 16,
   parameter int DATA_BITS     = 16,
   parameter int DEPTH_LOG2    = 8,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read_valid,
   input  logic [ADDR_BITS-1:0]  mem_read_address,
   output logic                  mem_read_ready,
   output logic [DATA_BITS-1:0]  mem_read_data,
   input  logic                  mem_write_valid,
   input  logic [ADDR_BITS-1:0]  mem_write_address,
   input  logic [DATA_BITS-1:0]  mem_write_data,
   output logic                  mem_write_ready,
   input  logic                  host_write_valid,
   input  logic [DEPTH_LOG2-1:0] host_write_address,
   input  logic [DATA_BITS-1:0]  host_write_data,
   output logic                  host_write_ready,
   output logic                  busy,
   output logic                  oob_error
);

   // state    | meaning
   // S_IDLE   | waiting for a request; priority host > core write > core read
   // S_HOST   | preload word written, host_write_ready high
   // S_WR_WAIT| core write accepted, latency counter running down
   // S_RD_WAIT| core read accepted, latency counter running down
   // S_RESPOND| core ready pulse high, always returns to S_IDLE

   localparam int LAT_MAX  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_BITS = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
   localparam logic [CNT_BITS-1:0] RD_LOAD = CNT_BITS'(READ_LATENCY - 1);
   localparam logic [CNT_BITS-1:0] WR_LOAD = CNT_BITS'(WRITE_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOST,
      S_WR_WAIT,
      S_RD_WAIT,
      S_RESPOND
   } state_t;

   logic [DATA_BITS-1:0] mem_array [2**DEPTH_LOG2];

   state_t                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [DATA_BITS-1:0]  wdata_q, wdata_d;
   logic                  rd_ready_q, rd_ready_d;
   logic                  wr_ready_q, wr_ready_d;
   logic                  host_ready_q, host_ready_d;
   logic [DATA_BITS-1:0]  rd_data_q, rd_data_d;
   logic                  busy_q, busy_d;
   logic                  oob_q, oob_d;

   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_waddr;
   logic [DATA_BITS-1:0]  mem_wdata;
   logic [DEPTH_LOG2-1:0] addr_idx;
   logic                  addr_oob;
   logic                  rd_req_oob;
   logic                  wr_req_oob;

   assign addr_idx   = addr_q[DEPTH_LOG2-1:0];
   assign addr_oob   = (addr_q >> DEPTH_LOG2) != '0;
   assign rd_req_oob = (mem_read_address >> DEPTH_LOG2) != '0;
   assign wr_req_oob = (mem_write_address >> DEPTH_LOG2) != '0;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rd_data_d    = rd_data_q;
      oob_d        = oob_q;
      rd_ready_d   = 1'b0;
      wr_ready_d   = 1'b0;
      host_ready_d = 1'b0;
      mem_we       = 1'b0;
      mem_waddr    = host_write_address;
      mem_wdata    = host_write_data;

      case (state_q)
         S_IDLE: begin
            if (host_write_valid) begin
               state_d      = S_HOST;
               host_ready_d = 1'b1;
               mem_we       = 1'b1;
            end else if (mem_write_valid) begin
               state_d = S_WR_WAIT;
               addr_d  = mem_write_address;
               wdata_d = mem_write_data;
               cnt_d   = WR_LOAD;
               if (wr_req_oob) oob_d = 1'b1;
            end else if (mem_read_valid) begin
               state_d = S_RD_WAIT;
               addr_d  = mem_read_address;
               cnt_d   = RD_LOAD;
               if (rd_req_oob) oob_d = 1'b1;
            end
         end
         S_HOST: state_d = S_IDLE;
         S_WR_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_RESPOND;
               wr_ready_d = 1'b1;
               mem_we     = !addr_oob;
               mem_waddr  = addr_idx;
               mem_wdata  = wdata_q;
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == '0) begin
               state_d    = S_RESPOND;
               rd_ready_d = 1'b1;
               rd_data_d  = addr_oob ? '0 : mem_array[addr_idx];
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
            end
         end
         S_RESPOND: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      // a request cut short by reset must never land in the array
      if (reset) mem_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rd_ready_q   <= 1'b0;
         wr_ready_q   <= 1'b0;
         host_ready_q <= 1'b0;
         rd_data_q    <= '0;
         busy_q       <= 1'b0;
         oob_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rd_ready_q   <= rd_ready_d;
         wr_ready_q   <= wr_ready_d;
         host_ready_q <= host_ready_d;
         rd_data_q    <= rd_data_d;
         busy_q       <= busy_d;
         oob_q        <= oob_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_array[mem_waddr] <= mem_wdata;
   end

   assign mem_read_ready   = rd_ready_q;
   assign mem_read_data    = rd_data_q;
   assign mem_write_ready  = wr_ready_q;
   assign host_write_ready = host_ready_q;
   assign busy             = busy_q;
   assign oob_error        = oob_q;

endmodule
